kv_cache_arb: RTL and testbench
===============================

Name: kv_cache_arb

Overview:
- Shares one single-port KV cache RAM (one K or V instance) between one append-only writer (projection write-back) and NREQ readers (cache loader, QK and attention-read stages).
- Grants one RAM access per cycle. The writer has priority; readers are served round-robin.
- Maintains the current sequence length and flags out-of-range reads.
- Sits between the attention top FSM and each kv_cache instance.

Parameters:
- NREQ, 2, number of read requesters
- SEQ_LEN, 2048, cache depth in tokens
- AW, $clog2(SEQ_LEN), address width
- LINE_W, 48, cache line width (HEADS*DW)
- RD_LAT, 1, RAM read latency in cycles (1..3)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clear  in  1  start a new sequence (seq_len -> 0)
- wr_req  in  1  append request
- wr_data  in  LINE_W  line to append
- wr_gnt  out  1  write accepted this cycle (combinational)
- rd_req  in  NREQ  per-reader read request
- rd_addr  in  NREQ*AW  per-reader token index; reader i uses slice [i*AW +: AW]
- rd_gnt  out  NREQ  one-hot read accept (combinational)
- rd_valid  out  NREQ  one-hot read-data return
- rd_err  out  1  returned read was out of range
- rd_data  out  LINE_W  returned line
- seq_len  out  AW+1  valid entries in cache
- full  out  1  seq_len == SEQ_LEN
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  LINE_W  RAM write data
- ram_dout  in  LINE_W  RAM read data, valid RD_LAT cycles after address

Behaviour:
- Reset values: rd_valid=0, rd_err=0, rd_data=0, seq_len=0, full=0, round-robin pointer=0, return pipeline flushed (in-flight reads dropped). While rst is high, wr_gnt=0, rd_gnt=0, ram_we=0.
- Handshake: a transaction occurs when req && gnt in the same cycle. A requester holds req and addr/data until granted. At most one grant (write or read) per cycle.
- Arbitration, cycle T:
  - If clear, no grants.
  - Else if wr_req && !full, wr_gnt=1.
  - Else grant the first asserted rd_req at or after the pointer, wrapping modulo NREQ.
  - The pointer moves to (granted index + 1) mod NREQ only on a read grant; write grants leave it unchanged.
- Write grant: ram_we=1, ram_addr=seq_len[AW-1:0], ram_din=wr_data, all combinational in T. seq_len increments at T+1. full asserts when seq_len reaches SEQ_LEN.
- Read grant with addr < seq_len: ram_we=0, ram_addr=rd_addr slice. rd_valid[i]=1 and rd_data=ram_dout are registered at T+RD_LAT+1 (latency 2 by default), rd_err=0.
- Read grant with addr >= seq_len: no RAM access is required (ram_addr is don't-care). The request still flows through the return pipeline and returns at the same latency with rd_err=1 and rd_data=0.
- Return pipeline: depth RD_LAT+1; each stage holds {valid, requester id, err}. Fully pipelined, so back-to-back read grants give back-to-back returns in grant order.
- Idle cycles: ram_we=0, ram_addr holds its last value, ram_din don't-care.
- full: wr_req is ignored (wr_gnt=0) and reads continue.
- clear: seq_len=0 and full=0 at T+1. In-flight reads still return, with their rd_err decided at grant time. clear together with wr_req: clear wins and the write is not granted.
- Read after write: a read of address seq_len-1, granted the cycle after its write, returns the new data (RAM is write-first over a cycle boundary).
- rst mid-operation: everything returns to reset values next cycle and no stale rd_valid is produced.

Decomposition:
- attn_pkg: LINE_W derivation (HEADS*DW), the requester-id type (logic [$clog2(NREQ)-1:0]), and the return-stage struct {valid, id, err}.
- Sub-module rr_arbiter #(N): request vector plus pointer in, one-hot grant and next pointer out. Reused for other shared units.

Test Plan:
- Reset, then 3 writes of 0xA..A, 0xB..B, 0xC..C -> ram_addr 0,1,2 with ram_we=1; seq_len=3 after the third write.
- Readers 0 and 1 both request every cycle, addr 1 and 2 -> grants alternate 0,1,0,1. Returns at T+2 carry 0xB..B and 0xC..C, rd_err=0.
- wr_req and rd_req[0] asserted together for 3 cycles -> 3 write grants first, then the read grant; round-robin pointer unchanged by the writes.
- Read addr 5 with seq_len=3 -> rd_valid[i] at T+2, rd_err=1, rd_data=0.
- SEQ_LEN=4 instance, 5 writes -> 4 granted, full=1, 5th wr_gnt=0. Then clear -> seq_len=0, full=0, and the held 5th write is granted to addr 0.
- Read granted, then rst asserted at T+1 -> no rd_valid at T+2; all outputs at reset values.

Source files
------------

// File: rtl/kv_cache_arb_pkg.sv
// Shared types and constants for the KV cache arbiter: cache line geometry,
// requester ids and the read-return pipeline stage.
package kv_cache_arb_pkg;

  localparam int HEADS     = 4;
  localparam int DW        = 12;
  localparam int KV_LINE_W = HEADS * DW;

  // Wide enough for up to 16 readers; narrower indices are zero-extended.
  localparam int RID_W = 4;
  typedef logic [RID_W-1:0] rid_t;

  typedef struct packed {
    logic valid;
    rid_t id;
    logic err;
  } ret_stage_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping,
// and reports the pointer value that follows the granted index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic [PW-1:0] next_ptr,
  output logic          any
);

  always_comb begin
    int idx;
    idx      = 0;
    gnt      = '0;
    gnt_idx  = '0;
    next_ptr = ptr;
    any      = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        next_ptr = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/kv_cache_arb.sv
// Single-port KV cache arbiter: one append-only writer with priority over
// NREQ round-robin readers, sequence-length tracking and range-checked reads.
module kv_cache_arb
  import kv_cache_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int SEQ_LEN = 2048,
  parameter int AW      = $clog2(SEQ_LEN),
  parameter int LINE_W  = KV_LINE_W,
  parameter int RD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 wr_req,
  input  logic [LINE_W-1:0]    wr_data,
  output logic                 wr_gnt,
  input  logic [NREQ-1:0]      rd_req,
  input  logic [NREQ*AW-1:0]   rd_addr,
  output logic [NREQ-1:0]      rd_gnt,
  output logic [NREQ-1:0]      rd_valid,
  output logic                 rd_err,
  output logic [LINE_W-1:0]    rd_data,
  output logic [AW:0]          seq_len,
  output logic                 full,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [LINE_W-1:0]    ram_din,
  input  logic [LINE_W-1:0]    ram_dout
);

  localparam int PW = ptr_width(NREQ);

  logic [AW:0]        seq_len_reg;
  logic [PW-1:0]      ptr_reg;
  logic [PW-1:0]      next_ptr;
  logic [PW-1:0]      gnt_idx;
  logic [AW-1:0]      ram_addr_reg;
  logic [AW-1:0]      sel_addr;
  logic [AW-1:0]      addr_slice [NREQ];
  logic               arb_en;
  logic               rd_any;
  logic               in_range;
  logic [NREQ-1:0]    rd_mask;
  ret_stage_t         ret_pipe [RD_LAT];
  ret_stage_t         ret_head;
  logic [NREQ-1:0]    rd_valid_reg;
  logic               rd_err_reg;
  logic [LINE_W-1:0]  rd_data_reg;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign addr_slice[gi] = rd_addr[gi*AW +: AW];
  end

  // clear and rst both suppress every grant in the cycle they are high.
  assign full    = (seq_len_reg == (AW+1)'(SEQ_LEN));
  assign arb_en  = !rst && !clear;
  assign wr_gnt  = arb_en && wr_req && !full;
  assign rd_mask = (arb_en && !wr_gnt) ? rd_req : '0;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .req      (rd_mask),
    .ptr      (ptr_reg),
    .gnt      (rd_gnt),
    .gnt_idx  (gnt_idx),
    .next_ptr (next_ptr),
    .any      (rd_any)
  );

  assign sel_addr = addr_slice[gnt_idx];
  assign in_range = ({1'b0, sel_addr} < seq_len_reg);
  assign ram_we   = wr_gnt;
  assign ram_din  = wr_data;

  always_comb begin
    ram_addr = ram_addr_reg;
    if (wr_gnt)      ram_addr = seq_len_reg[AW-1:0];
    else if (rd_any) ram_addr = sel_addr;
  end

  assign ret_head = ret_pipe[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_len_reg  <= '0;
      ptr_reg      <= '0;
      ram_addr_reg <= '0;
      for (int i = 0; i < RD_LAT; i++) ret_pipe[i] <= '0;
      rd_valid_reg <= '0;
      rd_err_reg   <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      if (clear)       seq_len_reg <= '0;
      else if (wr_gnt) seq_len_reg <= seq_len_reg + (AW+1)'(1);
      if (rd_any) ptr_reg <= next_ptr;
      if (wr_gnt || rd_any) ram_addr_reg <= ram_addr;
      // Range is decided at grant time so a later clear cannot change it.
      ret_pipe[0].valid <= rd_any;
      ret_pipe[0].id    <= RID_W'(gnt_idx);
      ret_pipe[0].err   <= !in_range;
      for (int i = 1; i < RD_LAT; i++) ret_pipe[i] <= ret_pipe[i-1];
      rd_valid_reg <= ret_head.valid ? (NREQ'(1) << ret_head.id) : '0;
      rd_err_reg   <= ret_head.valid && ret_head.err;
      if (ret_head.valid) rd_data_reg <= ret_head.err ? '0 : ram_dout;
    end
  end

  assign seq_len  = seq_len_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_err   = rd_err_reg;
  assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_kv_cache_arb.sv
// Randomised bench for kv_cache_arb against a transaction-level model of
// the cache (append log, round-robin order, timed return queue).
module tb_kv_cache_arb;

  localparam int NREQ    = 3;
  localparam int SEQ_LEN = 8;
  localparam int AW      = 3;
  localparam int LW      = 48;
  localparam int RD_LAT  = 2;

  logic              clk, rst, clear, wr_req, wr_gnt, rd_err, full, ram_we;
  logic [LW-1:0]     wr_data, rd_data, ram_din, ram_dout;
  logic [NREQ-1:0]   rd_req, rd_gnt, rd_valid;
  logic [NREQ*AW-1:0] rd_addr;
  logic [AW:0]       seq_len;
  logic [AW-1:0]     ram_addr;

  kv_cache_arb #(.NREQ(NREQ), .SEQ_LEN(SEQ_LEN), .AW(AW), .LINE_W(LW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_req(wr_req), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_err(rd_err), .rd_data(rd_data), .seq_len(seq_len),
    .full(full), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with RD_LAT-cycle registered read.
  logic [LW-1:0] ram [SEQ_LEN];
  logic [LW-1:0] rdp [RD_LAT];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    rdp[0] <= ram[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
  end
  assign ram_dout = rdp[RD_LAT-1];

  typedef struct {
    int            due;
    int            id;
    bit            err;
    logic [LW-1:0] data;
  } exp_t;

  exp_t          retq[$];
  int            cyc, m_seq, m_ptr, n_cmp, n_bad;
  logic [LW-1:0] m_mem [SEQ_LEN];
  bit            wr_pend, rst_i, clear_i, prev_rst, regs_ok, addr_known;
  logic [LW-1:0] wr_dat;
  bit            rd_pend [NREQ];
  logic [AW-1:0] rd_adr [NREQ];
  logic [AW-1:0] last_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle();
    exp_t e;
    int   er;
    bit   ew, in_r;
    @(negedge clk);
    cyc++;
    // Registered outputs as they stand in this cycle.
    if (regs_ok) begin
      if (retq.size() > 0 && retq[0].due == cyc) begin
        e = retq.pop_front();
        chk("rd_valid", 64'(rd_valid), 64'(1) << e.id);
        chk("rd_err", 64'(rd_err), 64'(e.err));
        chk("rd_data", 64'(rd_data), 64'(e.data));
        $display("cyc %0d RET id %0d err %0d data %h", cyc, e.id, e.err, rd_data);
      end else begin
        chk("rd_valid_idle", 64'(rd_valid), 64'(0));
        chk("rd_err_idle", 64'(rd_err), 64'(0));
      end
      if (prev_rst) chk("rst_rd_data", 64'(rd_data), 64'(0));
      chk("seq_len", 64'(seq_len), 64'(m_seq));
      chk("full", 64'(full), 64'(m_seq == SEQ_LEN));
    end
    rst = rst_i; clear = clear_i; wr_req = wr_pend; wr_data = wr_dat;
    for (int i = 0; i < NREQ; i++) begin
      rd_req[i] = rd_pend[i];
      rd_addr[i*AW +: AW] = rd_adr[i];
    end
    #1;
    ew = 1'b0; er = -1;
    if (!rst_i && !clear_i) begin
      if (wr_pend && m_seq < SEQ_LEN) ew = 1'b1;
      else
        for (int k = 0; k < NREQ; k++)
          if (er < 0 && rd_pend[(m_ptr + k) % NREQ]) er = (m_ptr + k) % NREQ;
    end
    chk("wr_gnt", 64'(wr_gnt), 64'(ew));
    chk("rd_gnt", 64'(rd_gnt), (er >= 0) ? (64'(1) << er) : 64'(0));
    chk("ram_we", 64'(ram_we), 64'(ew));
    if (ew) begin
      chk("ram_addr_wr", 64'(ram_addr), 64'(m_seq));
      chk("ram_din", 64'(ram_din), 64'(wr_dat));
      $display("cyc %0d WR addr %0d data %h", cyc, m_seq, wr_dat);
      m_mem[m_seq] = wr_dat;
      last_addr = AW'(m_seq);
      addr_known = 1'b1;
      m_seq++;
      wr_pend = 1'b0;
    end else if (er >= 0) begin
      in_r = (int'(rd_adr[er]) < m_seq);
      if (in_r) chk("ram_addr_rd", 64'(ram_addr), 64'(rd_adr[er]));
      e.due = cyc + RD_LAT + 1; e.id = er; e.err = !in_r;
      e.data = in_r ? m_mem[rd_adr[er]] : '0;
      retq.push_back(e);
      $display("cyc %0d RD id %0d addr %0d", cyc, er, rd_adr[er]);
      last_addr = rd_adr[er];
      addr_known = in_r;
      m_ptr = (er + 1) % NREQ;
      rd_pend[er] = 1'b0;
    end else if (addr_known && !rst_i) begin
      chk("ram_addr_hold", 64'(ram_addr), 64'(last_addr));
    end
    prev_rst = rst_i;
    if (rst_i) begin
      m_seq = 0; m_ptr = 0; retq.delete(); addr_known = 1'b0; regs_ok = 1'b1;
    end else if (clear_i) begin
      m_seq = 0;
    end
  endtask

  task automatic do_write(input logic [LW-1:0] d);
    wr_pend = 1'b1; wr_dat = d;
    for (int k = 0; k < 8 && wr_pend; k++) cycle();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; m_seq = 0; m_ptr = 0;
    wr_pend = 0; wr_dat = '0; clear_i = 0; prev_rst = 0; regs_ok = 0; addr_known = 0;
    last_addr = '0;
    for (int i = 0; i < NREQ; i++) begin rd_pend[i] = 0; rd_adr[i] = '0; end
    rst = 1'b1; clear = 1'b0; wr_req = 1'b0; wr_data = '0; rd_req = '0; rd_addr = '0;

    rst_i = 1; cycle(); cycle(); rst_i = 0;

    // Writes take priority over a reader pending throughout.
    rd_pend[0] = 1; rd_adr[0] = 0;
    do_write(48'hAAAA_AAAA_AAAA);
    do_write(48'hBBBB_BBBB_BBBB);
    do_write(48'hCCCC_CCCC_CCCC);
    repeat (2) cycle();

    // Two readers competing every cycle.
    repeat (6) begin
      if (!rd_pend[0]) begin rd_pend[0] = 1; rd_adr[0] = 1; end
      if (!rd_pend[1]) begin rd_pend[1] = 1; rd_adr[1] = 2; end
      cycle();
    end
    repeat (5) cycle();

    // Out-of-range read.
    rd_pend[2] = 1; rd_adr[2] = 5;
    repeat (5) cycle();

    // Fill to full, hold one more write, then clear releases it.
    for (int k = 0; k < 16 && m_seq < SEQ_LEN; k++)
      do_write({16'h1234, 32'($urandom)});
    wr_pend = 1; wr_dat = 48'hEEEE_EEEE_EEEE;
    repeat (3) cycle();
    clear_i = 1; cycle(); clear_i = 0;
    repeat (2) cycle();

    // Reset right after a read grant drops the in-flight return.
    rd_pend[1] = 1; rd_adr[1] = 0;
    cycle();
    rst_i = 1; cycle(); rst_i = 0;
    repeat (4) cycle();

    for (int n = 0; n < 1500; n++) begin
      rst_i   = ($urandom_range(0, 199) == 0);
      clear_i = ($urandom_range(0, 29) == 0);
      if (!wr_pend && $urandom_range(0, 2) == 0) begin
        wr_pend = 1; wr_dat = {16'($urandom), 32'($urandom)};
      end
      for (int i = 0; i < NREQ; i++)
        if (!rd_pend[i] && $urandom_range(0, 1) == 0) begin
          rd_pend[i] = 1; rd_adr[i] = AW'($urandom_range(0, SEQ_LEN - 1));
        end
      cycle();
    end
    rst_i = 0; clear_i = 0; wr_pend = 0;
    for (int i = 0; i < NREQ; i++) rd_pend[i] = 0;
    repeat (RD_LAT + 4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
